// File: rtl/pc_pkg.sv
// Shared constants for the program-counter controller: state encoding,
// default step/reset vector, and the redirect alignment check.
package pc_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int unsigned PC_STEP_DEF      = 4;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;

  function automatic logic addr_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_redir_buf.sv
// One-entry pending-redirect holding register; clear wins over capture,
// and a newer capture overwrites an older one.
module pc_redir_buf
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            res,
  input  logic            capture,
  input  logic            clear,
  input  logic [XLEN-1:0] target_in,
  output logic            valid,
  output logic [XLEN-1:0] target
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d  = 1'b1;
      target_d = target_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: boot/run/halt sequencing, next-pc selection
// with trap > redirect > pending redirect > sequential step.
//   state | meaning
//   BOOT  | one cycle after reset, pc held, not yet a valid fetch address
//   RUN   | fetching; pc advances when En is high or on a trap
//   HALT  | pc frozen; redirects are buffered until resume or trap
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(PC_RESET_VEC_DEF),
  parameter int unsigned      STEP      = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            res,
  input  logic            En,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_old,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_old_q, pc_old_d, bad_addr_q, bad_addr_d;
  logic            pc_valid_q, pc_valid_d, halted_q, halted_d;
  logic            misalign_q, misalign_d;

  logic            pend_valid, pend_capture, pend_clear;
  logic [XLEN-1:0] pend_target;
  logic            advance, redir_apply;
  logic [XLEN-1:0] redir_addr;

  pc_redir_buf #(.XLEN(XLEN)) u_redir_buf (
    .clk       (clk),
    .res       (res),
    .capture   (pend_capture),
    .clear     (pend_clear),
    .target_in (redir_target),
    .valid     (pend_valid),
    .target    (pend_target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_old_d     = pc_old_q;
    bad_addr_d   = bad_addr_q;
    misalign_d   = 1'b0;
    pend_capture = 1'b0;
    pend_clear   = 1'b0;
    advance      = 1'b0;
    redir_apply  = 1'b0;
    redir_addr   = redir_target;

    case (state_q)
      ST_BOOT: begin
        advance = trap_valid;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        advance      = En | trap_valid;
        pend_capture = redir_valid & ~advance;
        if (halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        advance      = trap_valid;
        pend_capture = redir_valid & ~trap_valid;
        if (trap_valid || resume) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase

    // Every advance consumes whatever is pending, whichever source wins.
    if (advance) begin
      pc_old_d   = pc_q;
      pend_clear = 1'b1;
      if (trap_valid) begin
        pc_d = trap_vec;
      end else if (redir_valid) begin
        redir_apply = 1'b1;
        redir_addr  = redir_target;
      end else if (pend_valid) begin
        redir_apply = 1'b1;
        redir_addr  = pend_target;
      end else begin
        pc_d = pc_q + XLEN'(STEP);
      end
      if (redir_apply) begin
        if (addr_aligned(redir_addr[1:0])) begin
          pc_d = redir_addr;
        end else begin
          pc_d       = trap_vec;
          misalign_d = 1'b1;
          bad_addr_d = redir_addr;
        end
      end
    end

    pc_valid_d = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pc_old_q   <= RESET_VEC;
      bad_addr_q <= '0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_old_q   <= pc_old_d;
      bad_addr_q <= bad_addr_d;
      pc_valid_q <= pc_valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pc_old   = pc_old_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the pc sequencing rules.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        res, En, redir_valid, trap_valid, halt_req, resume;
  logic [31:0] redir_target, trap_vec;
  logic [31:0] pc, pc_old, bad_addr;
  logic        pc_valid, halted, misalign;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  bit          m_booting, m_halted, m_valid, m_mis;
  logic [31:0] m_pc, m_old, m_bad;
  logic [31:0] m_pend[$];

  pc_ctrl #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4)) dut (
    .clk          (clk),
    .res          (res),
    .En           (En),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .trap_valid   (trap_valid),
    .trap_vec     (trap_vec),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .pc_old       (pc_old),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .misalign     (misalign),
    .bad_addr     (bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt, npc;
    bit          is_redir;
    m_mis = 1'b0;
    if (!res) begin
      m_booting = 1; m_halted = 0; m_valid = 0;
      m_pc = 32'h0; m_old = 32'h0; m_bad = 32'h0;
      m_pend.delete();
      return;
    end
    if (m_booting) begin
      m_booting = 0; m_valid = 1;
      if (trap_valid) begin m_old = m_pc; m_pc = trap_vec; end
      return;
    end
    if (m_halted) begin
      if (trap_valid) begin
        m_old = m_pc; m_pc = trap_vec; m_pend.delete(); m_halted = 0;
      end else begin
        if (redir_valid) begin m_pend.delete(); m_pend.push_back(redir_target); end
        if (resume) m_halted = 0;
      end
      m_valid = !m_halted;
      return;
    end
    if (En || trap_valid) begin
      is_redir = 0;
      tgt = 32'h0;
      if (trap_valid) npc = trap_vec;
      else if (redir_valid) begin is_redir = 1; tgt = redir_target; end
      else if (m_pend.size() > 0) begin is_redir = 1; tgt = m_pend[0]; end
      else npc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      if (is_redir) begin
        if (tgt % 4 == 0) npc = tgt;
        else begin npc = trap_vec; m_mis = 1; m_bad = tgt; end
      end
      m_old = m_pc;
      m_pc  = npc;
      m_pend.delete();
    end else if (redir_valid) begin
      m_pend.delete();
      m_pend.push_back(redir_target);
    end
    if (halt_req) m_halted = 1;
    m_valid = !m_halted;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_old", pc_old, m_old);
    chk("pc_valid", 32'(pc_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("bad_addr", bad_addr, m_bad);
  endtask

  task automatic set_in(input bit r, input bit e, input bit rv, input logic [31:0] rt,
                        input bit tv, input bit h, input bit rs);
    res = r; En = e; redir_valid = rv; redir_target = rt;
    trap_valid = tv; halt_req = h; resume = rs;
  endtask

  initial begin
    logic [31:0] t;
    trap_vec = 32'h80;
    set_in(0, 0, 0, 32'h0, 0, 0, 0);
    step();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", 32'(pc_valid), 32'h0);

    // BOOT must ignore redirect and halt requests
    set_in(1, 1, 1, 32'h440, 0, 1, 0);
    step();
    chk("boot_run", 32'(pc_valid), 32'h1);
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    step();
    chk("seq_pc8", pc, 32'h8);
    chk("seq_old4", pc_old, 32'h4);

    set_in(1, 0, 1, 32'h100, 0, 0, 0);
    step();
    chk("stall_hold", pc, 32'h8);
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    chk("pend_apply", pc, 32'h100);
    chk("pend_old", pc_old, 32'h8);

    set_in(1, 1, 1, 32'h102, 0, 0, 0);
    step();
    chk("mis_pc", pc, 32'h80);
    chk("mis_flag", 32'(misalign), 32'h1);
    chk("mis_bad", bad_addr, 32'h102);
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    chk("mis_pulse", 32'(misalign), 32'h0);

    set_in(1, 1, 1, 32'h200, 1, 1, 0);
    step();
    chk("trap_pc", pc, 32'h80);
    chk("trap_halt", 32'(halted), 32'h1);

    set_in(1, 1, 1, 32'h300, 0, 0, 0);
    step();
    chk("halt_hold", pc, 32'h80);
    set_in(1, 0, 0, 32'h0, 0, 1, 1);
    step();
    chk("resume", 32'(halted), 32'h0);
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    chk("resume_pend", pc, 32'h300);
    set_in(0, 1, 0, 32'h0, 0, 0, 0);
    step();
    chk("rst_pc", pc, 32'h0);

    set_in(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step();
    step();
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_old", pc_old, 32'hFFFF_FFFC);

    // reset while halted with a redirect pending discards it
    set_in(1, 1, 0, 32'h0, 0, 1, 0);
    step();
    set_in(1, 0, 1, 32'h500, 0, 0, 0);
    step();
    set_in(0, 0, 0, 32'h0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 32'h0, 0, 0, 0);
    step();
    step();
    chk("rst_pend_clr", pc, 32'h4);

    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      trap_vec = $urandom & 32'hFFFF_FFFC;
      set_in($urandom_range(39) != 0, $urandom_range(9) < 7, $urandom_range(3) == 0, t,
             $urandom_range(11) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
